// File: rtl/win3_reader_pkg.sv
// Shared types for the sliding-window FIFO read controller:
// FSM encoding, per-pop tag and the window tap count.
package win3_reader_pkg;

  localparam int NUM_TAPS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic keep;
    logic last;
    logic frame_last;
  } win_tag_t;

endpackage

// File: rtl/win3_reader_skid2.sv
// Two-entry valid/ready buffer; the head entry is always presented on the outputs.
module win_skid2 #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  input  logic             head_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic [1:0]       count_reg;
  logic             pop;

  assign head_valid = (count_reg != 2'd0);
  assign head_data  = mem_reg[rd_ptr_reg];
  assign count      = count_reg;
  assign pop        = head_valid & head_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/win3_reader.sv
// Read-side controller for the pop-1/output-3 line FIFO: issues keep/drop pops,
// strips the two trailing pixels per row and buffers kept windows for the PE.
module win3_reader
  import win3_reader_pkg::*;
#(
  parameter int DAT_WIDTH     = 8,
  parameter int FF_ADDR_WIDTH = 3,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          row_len,
  input  logic [LEN_WIDTH-1:0]          num_rows,
  output logic                          fifo_rd_req,
  input  logic [NUM_TAPS*DAT_WIDTH-1:0] fifo_rd_data,
  input  logic                          fifo_rd_val,
  input  logic [FF_ADDR_WIDTH:0]        fifo_count,
  input  logic                          fifo_empty,
  output logic [NUM_TAPS*DAT_WIDTH-1:0] win_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic                          win_last,
  output logic                          win_frame_last,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int WIN_WIDTH = NUM_TAPS * DAT_WIDTH;
  localparam int CNT_WIDTH = FF_ADDR_WIDTH + 1;

  state_t               state_reg, state_next;
  logic [LEN_WIDTH-1:0] col_reg, col_next;
  logic [LEN_WIDTH-1:0] row_reg, row_next;
  logic [LEN_WIDTH-1:0] last_col_reg, last_row_reg;
  logic                 drop_cnt_reg, drop_cnt_next;
  win_tag_t             tag_reg, tag_next;
  logic                 pend_reg;
  logic                 cfg_err_reg;
  logic                 cfg_ok, cfg_load;
  logic [1:0]           buf_cnt;
  logic [WIN_WIDTH+1:0] head;

  assign cfg_ok = (row_len >= LEN_WIDTH'(NUM_TAPS)) && (num_rows != '0);

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    drop_cnt_next = drop_cnt_reg;
    tag_next      = '0;
    fifo_rd_req   = 1'b0;
    done          = 1'b0;
    cfg_load      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && cfg_ok) begin
          cfg_load   = 1'b1;
          col_next   = '0;
          row_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // An in-flight keep pop already owns a buffer slot.
        if (fifo_count >= CNT_WIDTH'(NUM_TAPS) &&
            (buf_cnt + {1'b0, tag_reg.keep}) < 2'd2) begin
          fifo_rd_req   = 1'b1;
          tag_next.keep = 1'b1;
          col_next      = col_reg + LEN_WIDTH'(1);
          if (col_reg == last_col_reg) begin
            tag_next.last       = 1'b1;
            tag_next.frame_last = (row_reg == last_row_reg);
            drop_cnt_next       = 1'b0;
            state_next          = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!fifo_empty) begin
          fifo_rd_req = 1'b1;
          if (drop_cnt_reg) begin
            if (row_reg == last_row_reg) begin
              state_next = ST_DRAIN;
            end else begin
              row_next   = row_reg + LEN_WIDTH'(1);
              col_next   = '0;
              state_next = ST_RUN;
            end
          end else begin
            drop_cnt_next = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (buf_cnt == 2'd0 && !pend_reg) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      last_col_reg <= '0;
      last_row_reg <= '0;
      drop_cnt_reg <= 1'b0;
      tag_reg      <= '0;
      pend_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      drop_cnt_reg <= drop_cnt_next;
      tag_reg      <= tag_next;
      pend_reg     <= fifo_rd_req;
      cfg_err_reg  <= start && (state_reg == ST_IDLE) && !cfg_ok;
      if (cfg_load) begin
        last_col_reg <= row_len - LEN_WIDTH'(NUM_TAPS);
        last_row_reg <= num_rows - LEN_WIDTH'(1);
      end
    end
  end

  win_skid2 #(
    .WIDTH(WIN_WIDTH + 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_rd_val & tag_reg.keep),
    .push_data ({fifo_rd_data, tag_reg.last, tag_reg.frame_last}),
    .head_data (head),
    .head_valid(win_valid),
    .head_ready(win_ready),
    .count     (buf_cnt)
  );

  assign win_data       = head[WIN_WIDTH+1:2];
  assign win_last       = head[1] & win_valid;
  assign win_frame_last = head[0] & win_valid;
  assign busy           = (state_reg != ST_IDLE);
  assign cfg_err        = cfg_err_reg;

endmodule

// File: tb/tb_win3_reader.sv
// Directed bench for win3_reader with a behavioural pop-1/output-3 FIFO model.
module tb_win3_reader;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LW-1:0]   row_len = '0;
  logic [LW-1:0]   num_rows = '0;
  logic            fifo_rd_req;
  logic [3*DW-1:0] fifo_rd_data;
  logic            fifo_rd_val;
  logic [AW:0]     fifo_count;
  logic            fifo_empty;
  logic [3*DW-1:0] win_data;
  logic            win_valid;
  logic            win_ready = 1'b0;
  logic            win_last;
  logic            win_frame_last;
  logic            busy;
  logic            done;
  logic            cfg_err;

  always #5 clk = ~clk;

  win3_reader #(
    .DAT_WIDTH(DW), .FF_ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data), .fifo_rd_val(fifo_rd_val),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_last(win_last), .win_frame_last(win_frame_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // Line FIFO model: pop removes the oldest pixel, read data is the 3 oldest.
  logic [DW-1:0]   fmem [8];
  logic [AW-1:0]   frd, fwr;
  logic [AW:0]     fcnt;
  logic            push_en = 1'b0;
  logic [DW-1:0]   push_data = '0;
  logic [3*DW-1:0] rdata_q;
  logic            rval_q;
  logic            do_pop, do_push;

  assign do_pop       = fifo_rd_req && (fcnt != 4'd0);
  assign do_push      = push_en && (fcnt != 4'd8);
  assign fifo_count   = fcnt;
  assign fifo_empty   = (fcnt == 4'd0);
  assign fifo_rd_data = rdata_q;
  assign fifo_rd_val  = rval_q;

  always @(posedge clk) begin
    if (rst) begin
      frd <= '0; fwr <= '0; fcnt <= '0; rval_q <= 1'b0; rdata_q <= '0;
    end else begin
      rval_q <= fifo_rd_req;
      if (fifo_rd_req) rdata_q <= {fmem[frd + 3'd2], fmem[frd + 3'd1], fmem[frd]};
      if (do_pop) frd <= frd + 3'd1;
      if (do_push) begin
        fmem[fwr] <= push_data;
        fwr <= fwr + 3'd1;
      end
      fcnt <= fcnt + 4'(do_push) - 4'(do_pop);
    end
  end

  typedef struct packed {
    logic [3*DW-1:0] data;
    logic            last;
    logic            fl;
  } win_t;

  win_t rx_q[$];
  int   rx_cyc[$];
  int   cyc = 0, req_cnt = 0, done_cnt = 0, cfg_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && win_valid && win_ready) begin
      rx_q.push_back('{data: win_data, last: win_last, fl: win_frame_last});
      rx_cyc.push_back(cyc);
    end
    if (fifo_rd_req) req_cnt <= req_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cfg_err) cfg_cnt <= cfg_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input int v);
    push_en   = 1'b1;
    push_data = DW'(v);
    tick();
    push_en   = 1'b0;
  endtask

  task automatic pulse_start(input int rl, input int nr);
    start    = 1'b1;
    row_len  = LW'(rl);
    num_rows = LW'(nr);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_win(input string tag, input int idx, input win_t exp);
    if (idx < rx_q.size()) begin
      check($sformatf("%s_data", tag), 32'(rx_q[idx].data), 32'(exp.data));
      check($sformatf("%s_last", tag), 32'(rx_q[idx].last), 32'(exp.last));
      check($sformatf("%s_frame_last", tag), 32'(rx_q[idx].fl), 32'(exp.fl));
    end else begin
      check($sformatf("%s_missing", tag), 32'(rx_q.size()), 32'(idx + 1));
    end
  endtask

  typedef struct {
    int rl; int nr; int base; int npix; int hold; int nwin; int widx; int npops;
  } vec_t;

  vec_t vecs[3];
  win_t exps[13];

  initial begin : main
    int brx, breq, bdone, bcfg;
    int bad_rl[3];
    int bad_nr[3];

    vecs[0] = '{5, 1, 10, 5, 0, 3, 0, 5};
    vecs[1] = '{4, 2, 1, 8, 0, 4, 3, 8};
    vecs[2] = '{8, 1, 20, 8, 10, 6, 7, 8};
    exps[0]  = '{data: {8'd12, 8'd11, 8'd10}, last: 1'b0, fl: 1'b0};
    exps[1]  = '{data: {8'd13, 8'd12, 8'd11}, last: 1'b0, fl: 1'b0};
    exps[2]  = '{data: {8'd14, 8'd13, 8'd12}, last: 1'b1, fl: 1'b1};
    exps[3]  = '{data: {8'd3, 8'd2, 8'd1},    last: 1'b0, fl: 1'b0};
    exps[4]  = '{data: {8'd4, 8'd3, 8'd2},    last: 1'b1, fl: 1'b0};
    exps[5]  = '{data: {8'd7, 8'd6, 8'd5},    last: 1'b0, fl: 1'b0};
    exps[6]  = '{data: {8'd8, 8'd7, 8'd6},    last: 1'b1, fl: 1'b1};
    exps[7]  = '{data: {8'd22, 8'd21, 8'd20}, last: 1'b0, fl: 1'b0};
    exps[8]  = '{data: {8'd23, 8'd22, 8'd21}, last: 1'b0, fl: 1'b0};
    exps[9]  = '{data: {8'd24, 8'd23, 8'd22}, last: 1'b0, fl: 1'b0};
    exps[10] = '{data: {8'd25, 8'd24, 8'd23}, last: 1'b0, fl: 1'b0};
    exps[11] = '{data: {8'd26, 8'd25, 8'd24}, last: 1'b0, fl: 1'b0};
    exps[12] = '{data: {8'd27, 8'd26, 8'd25}, last: 1'b1, fl: 1'b1};
    bad_rl = '{2, 0, 5};
    bad_nr = '{1, 3, 0};

    // Reset state
    repeat (3) tick();
    check("rst_outputs", 32'({win_valid, win_last, win_frame_last, busy, done, cfg_err, fifo_rd_req}), 32'd0);
    check("rst_win_data", 32'(win_data), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      brx = rx_q.size(); breq = req_cnt; bdone = done_cnt;
      win_ready = (vecs[v].hold == 0);
      for (int i = 0; i < vecs[v].npix; i++) push_pix(vecs[v].base + i);
      pulse_start(vecs[v].rl, vecs[v].nr);
      check($sformatf("v%0d_busy_rise", v), 32'(busy), 32'd1);
      if (vecs[v].hold > 0) begin
        bcfg = cfg_cnt;
        pulse_start(2, 1);
        repeat (vecs[v].hold - 1) tick();
        check("busy_start_ignored", 32'(cfg_cnt - bcfg), 32'd0);
        check("bp_keep_pops", 32'(req_cnt - breq), 32'd2);
        check("bp_req_low", 32'(fifo_rd_req), 32'd0);
        check("bp_buf_cnt", 32'(dut.buf_cnt), 32'd2);
        check("bp_win_valid", 32'(win_valid), 32'd1);
        win_ready = 1'b1;
      end
      wait_done(bdone, 300);
      check($sformatf("v%0d_busy_fall", v), 32'(busy), 32'd0);
      repeat (3) tick();
      check($sformatf("v%0d_done_once", v), 32'(done_cnt - bdone), 32'd1);
      check($sformatf("v%0d_win_count", v), 32'(rx_q.size() - brx), 32'(vecs[v].nwin));
      for (int k = 0; k < vecs[v].nwin; k++)
        check_win($sformatf("v%0d_w%0d", v, k), brx + k, exps[vecs[v].widx + k]);
      check($sformatf("v%0d_pops", v), 32'(req_cnt - breq), 32'(vecs[v].npops));
      check($sformatf("v%0d_fifo_empty", v), 32'(fifo_empty), 32'd1);
      if (rx_q.size() > brx)
        check($sformatf("v%0d_done_latency", v),
              32'((done_cyc - rx_cyc[rx_q.size() - 1]) inside {1, 2}), 32'd1);
    end

    // Starvation: two pixels in RUN must not pop; the third must
    brx = rx_q.size(); breq = req_cnt; bdone = done_cnt;
    win_ready = 1'b1;
    pulse_start(3, 1);
    push_pix(40);
    push_pix(41);
    repeat (5) tick();
    check("starve_no_req", 32'(req_cnt - breq), 32'd0);
    check("starve_count2", 32'(fifo_count), 32'd2);
    push_pix(42);
    check("starve_count3", 32'(fifo_count), 32'd3);
    tick();
    tick();
    check("starve_req_after3", 32'((req_cnt - breq) >= 1), 32'd1);
    wait_done(bdone, 100);
    check_win("starve_w0", brx, '{data: {8'd42, 8'd41, 8'd40}, last: 1'b1, fl: 1'b1});
    check("starve_pops", 32'(req_cnt - breq), 32'd3);
    check("starve_fifo_empty", 32'(fifo_empty), 32'd1);

    // Illegal configurations
    for (int k = 0; k < 3; k++) begin
      bcfg = cfg_cnt; breq = req_cnt;
      pulse_start(bad_rl[k], bad_nr[k]);
      check($sformatf("cfg%0d_busy", k), 32'(busy), 32'd0);
      tick();
      tick();
      check($sformatf("cfg%0d_err_pulse", k), 32'(cfg_cnt - bcfg), 32'd1);
      check($sformatf("cfg%0d_no_req", k), 32'(req_cnt - breq), 32'd0);
      check($sformatf("cfg%0d_busy_after", k), 32'(busy), 32'd0);
    end

    // Reset mid-frame with one window buffered
    win_ready = 1'b0;
    push_pix(50);
    push_pix(51);
    push_pix(52);
    pulse_start(5, 1);
    repeat (4) tick();
    check("pre_rst_buf_cnt", 32'(dut.buf_cnt), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_outputs", 32'({win_valid, win_last, win_frame_last, busy, done, cfg_err, fifo_rd_req}), 32'd0);
    check("mid_rst_win_data", 32'(win_data), 32'd0);
    check("mid_rst_buf_cnt", 32'(dut.buf_cnt), 32'd0);
    rst = 1'b0;
    tick();
    brx = rx_q.size(); breq = req_cnt; bdone = done_cnt;
    win_ready = 1'b1;
    push_pix(60);
    push_pix(61);
    push_pix(62);
    pulse_start(3, 1);
    wait_done(bdone, 100);
    check_win("post_rst_w0", brx, '{data: {8'd62, 8'd61, 8'd60}, last: 1'b1, fl: 1'b1});
    check("post_rst_pops", 32'(req_cnt - breq), 32'd3);
    check("post_rst_win_count", 32'(rx_q.size() - brx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
